// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared constants and types for the Fibonacci request arbiter slice.
//   IDX_W        : width of a Fibonacci index
//   F_W          : width of a Fibonacci result from the core
//   MAX_IDX      : largest index whose result still fits in F_W bits
//   OVF_SENTINEL : rsp_data value returned for a rejected (too large) index
//   state_t      : arbiter FSM states
// ---------------------------------------------------------------------------
package fib_pkg;

    localparam int IDX_W   = 5;
    localparam int F_W     = 20;
    localparam int MAX_IDX = 30;

    localparam logic [F_W-1:0] OVF_SENTINEL = {F_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    // True when fib(idx) would not fit in the F_W-bit core result.
    function automatic logic idx_overflows(input logic [IDX_W-1:0] idx);
        return (int'(idx) > MAX_IDX);
    endfunction

endpackage

// File: rtl/fib_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// fib_req_arbiter_if
// Requester-side bus of the Fibonacci arbiter.
//   req       : per-requester request level
//   req_idx   : packed indices, slot k = [k*IDX_W +: IDX_W]
//   req_ack   : one-hot pulse, request k accepted
//   rsp_valid : one-hot pulse, response for requester k
//   rsp_data  : result, valid with rsp_valid
//   rsp_err   : error flag, valid with rsp_valid
// Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface fib_req_arbiter_if #(
    parameter int N_REQ = 4
);
    import fib_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDX_W-1:0] req_idx;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       rsp_valid;
    logic [F_W-1:0]         rsp_data;
    logic                   rsp_err;

    modport master (
        output req, req_idx,
        input  req_ack, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_idx,
        output req_ack, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/fib_req_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: picks the first set request bit at or
// above the pointer, wrapping around to bit 0.
//   req_i     : request vector
//   ptr_i     : highest-priority position this round
//   gnt_o     : one-hot grant (zero when nothing is requested)
//   gnt_idx_o : binary index of the granted bit
//   any_o     : at least one request is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             any_o
);

    // Walk the positions in priority order starting at the pointer; the
    // first requester found wins and later ones are masked by 'found'.
    always_comb begin
        logic [PTR_W-1:0] k;
        logic             found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        k         = '0;
        for (int off = 0; off < N; off++) begin
            k = PTR_W'((int'(ptr_i) + off) % N);
            if (!found && req_i[k]) begin
                found     = 1'b1;
                gnt_o[k]  = 1'b1;
                gnt_idx_o = k;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fib_req_arbiter.sv
// ---------------------------------------------------------------------------
// fib_req_arbiter
// Round-robin scheduler sharing one Fibonacci core between N_REQ requesters.
// One index is accepted per grant, the core is started, the result is
// captured and returned only to the winning requester. Indices whose result
// would overflow F_W bits are rejected without starting the core, and a
// watchdog aborts a core that never signals completion.
//   clk, reset_n    : clock, asynchronous active-low reset
//   bus (slave)     : requester-side request/response bus
//   busy            : FSM is not IDLE
//   fib_start       : one-cycle start pulse to the core
//   fib_i           : index to the core, held until the next grant
//   fib_ready       : core idle
//   fib_done_tick   : core completion pulse
//   fib_f           : core result, valid with fib_done_tick
// ---------------------------------------------------------------------------
module fib_req_arbiter
    import fib_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fib_req_arbiter_if.slave     bus,
    output logic                 busy,
    output logic                 fib_start,
    output logic [IDX_W-1:0]     fib_i,
    input  logic                 fib_ready,
    input  logic                 fib_done_tick,
    input  logic [F_W-1:0]       fib_f
);

    localparam int GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // The watchdog is cleared in LAUNCH and counts WAIT cycles from zero, so
    // leaving WAIT when it holds TIMEOUT-2 puts the error response exactly
    // TIMEOUT cycles after the fib_start pulse.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]   gnt_oh_q, gnt_oh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [WDW-1:0]     wdog_q, wdog_d;
    logic               ovf_q, ovf_d;
    logic [F_W-1:0]     data_q, data_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [GW-1:0]      pick_idx;
    logic               any_req;
    logic [IDX_W-1:0]   pick_val;

    rr_picker #(
        .N     (N_REQ),
        .PTR_W (GW)
    ) u_picker (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (any_req)
    );

    assign pick_val = bus.req_idx[pick_idx*IDX_W +: IDX_W];

    // State and transaction registers; a reset drops any transaction in
    // flight without producing a response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            wdog_q   <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            wdog_q   <= wdog_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic. The response data/flag are loaded on the way into
    // RESP so they appear with rsp_valid and then hold until the next RESP.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gnt_oh_d = gnt_oh_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (any_req && fib_ready) begin
                    grant_d  = pick_idx;
                    gnt_oh_d = pick_gnt;
                    idx_d    = pick_val;
                    if (idx_overflows(pick_val)) begin
                        ovf_d   = 1'b1;
                        data_d  = OVF_SENTINEL;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        ovf_d   = 1'b0;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion is checked first so a done_tick landing on the
                // timeout cycle still counts as success.
                if (fib_done_tick) begin
                    data_d  = fib_f;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wdog_q == WD_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            RESP: begin
                ptr_d   = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + GW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Rejected indices never visit LAUNCH, so their acknowledge is issued
    // together with the error response.
    assign bus.req_ack   = ((state_q == LAUNCH) || ((state_q == RESP) && ovf_q))
                           ? gnt_oh_q : '0;
    assign bus.rsp_valid = (state_q == RESP) ? gnt_oh_q : '0;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);
    assign fib_start     = (state_q == LAUNCH);
    assign fib_i         = idx_q;

endmodule

// File: tb/tb_fib_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fib_req_arbiter
// Self-checking bench for fib_req_arbiter with a behavioural Fibonacci core.
// Expected responses are queued when a request is driven and popped when
// the arbiter answers.
// ---------------------------------------------------------------------------
module tb_fib_req_arbiter;
    import fib_pkg::*;

    localparam int N        = 4;
    localparam int CORE_LAT = 6;

    typedef struct {
        logic [N-1:0]   vec;
        logic [F_W-1:0] data;
        logic           err;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             busy;
    logic             fib_start;
    logic [IDX_W-1:0] fib_i;
    logic             fib_ready;
    logic             fib_done_tick;
    logic [F_W-1:0]   fib_f = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pushed = 0;
    int n_rsp_seen = 0;

    logic           core_run = 1'b0;
    logic           core_done = 1'b0;
    logic           core_hang = 1'b0;
    logic           core_force_busy = 1'b0;
    logic           spur_done = 1'b0;
    int             core_cnt = 0;
    logic [F_W-1:0] core_res = '0;
    int             done_cyc = -1;

    bit             got;
    int             ack_cyc, start_cyc, rsp_cyc, ack_n;
    logic [N-1:0]   ack_vec, rsp_vec;
    logic [F_W-1:0] rsp_d;
    logic           rsp_e;

    fib_req_arbiter_if #(.N_REQ(N)) bus();

    fib_req_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .busy          (busy),
        .fib_start     (fib_start),
        .fib_i         (fib_i),
        .fib_ready     (fib_ready),
        .fib_done_tick (fib_done_tick),
        .fib_f         (fib_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [F_W-1:0] fib_ref(input logic [IDX_W-1:0] n);
        logic [31:0] a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[F_W-1:0];
    endfunction

    // Behavioural core: busy for CORE_LAT cycles after a start, then a
    // one-cycle done pulse; core_hang makes it swallow the start.
    assign fib_ready     = !core_run && !core_force_busy;
    assign fib_done_tick = core_done || spur_done;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (!reset_n) begin
            core_run = 1'b0;
        end else if (core_run) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_run  = 1'b0;
                core_done = 1'b1;
                fib_f     = core_res;
                done_cyc  = cyc;
            end
        end else if (fib_start && !core_hang) begin
            core_run = 1'b1;
            core_cnt = CORE_LAT;
            core_res = fib_ref(fib_i);
        end
    end

    always @(negedge clk) begin
        if (bus.rsp_valid != '0) n_rsp_seen++;
    end

    task automatic set_idx(input int k, input logic [IDX_W-1:0] v);
        bus.req_idx[k*IDX_W +: IDX_W] = v;
    endtask

    task automatic expect_rsp(input int k, input logic [F_W-1:0] d, input logic e);
        exp_t x;
        x.vec    = '0;
        x.vec[k] = 1'b1;
        x.data   = d;
        x.err    = e;
        sb.push_back(x);
        n_pushed++;
    endtask

    // Runs the bus until the next response (or the budget), dropping each
    // request bit the cycle it is acknowledged and recording event cycles.
    task automatic run_until_rsp(input int budget);
        got = 0; ack_cyc = -1; start_cyc = -1; rsp_cyc = -1; ack_n = -1;
        ack_vec = '0; rsp_vec = '0; rsp_d = '0; rsp_e = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (fib_start && start_cyc < 0) start_cyc = cyc;
            if (bus.req_ack != '0 && ack_cyc < 0) begin
                ack_cyc = cyc;
                ack_vec = bus.req_ack;
                ack_n   = n;
                bus.req = bus.req & ~bus.req_ack;
            end
            if (bus.rsp_valid != '0) begin
                rsp_cyc = cyc;
                rsp_vec = bus.rsp_valid;
                rsp_d   = bus.rsp_data;
                rsp_e   = bus.rsp_err;
                got     = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.req_idx = '0;
        #1;
        n_cmp++;
        if ({bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: ack=%b vld=%b data=%h err=%b busy=%b start=%b i=%0d, required all 0",
                     bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i} !== '0) begin
            n_err++;
            $display("[TB] FAIL post_reset_idle: ack=%b vld=%b data=%h err=%b busy=%b start=%b i=%0d, required all 0",
                     bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i);
        end
    endtask

    task automatic test_round_robin();
        set_idx(0, 5); set_idx(1, 20); set_idx(2, 25); set_idx(3, 30);
        expect_rsp(0, 20'd5, 1'b0);
        expect_rsp(1, 20'd6765, 1'b0);
        expect_rsp(2, 20'd75025, 1'b0);
        expect_rsp(3, 20'd832040, 1'b0);
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            run_until_rsp(40);
            ex = sb.pop_front();
            n_cmp++;
            if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
                n_err++;
                $display("[TB] FAIL rr_rsp%0d: ack=%b rsp=%b data=%0d err=%b, required ack=%b rsp=%b data=%0d err=%b",
                         k, ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
            end
        end
        // Pointer has wrapped to 0: requester 0 must beat requester 3.
        @(negedge clk);
        set_idx(0, 3); set_idx(3, 7);
        expect_rsp(0, 20'd2, 1'b0);
        expect_rsp(3, 20'd13, 1'b0);
        bus.req = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            run_until_rsp(40);
            ex = sb.pop_front();
            n_cmp++;
            if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
                n_err++;
                $display("[TB] FAIL rr_wrap%0d: ack=%b rsp=%b data=%0d err=%b, required ack=%b rsp=%b data=%0d err=%b",
                         k, ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_idx(0, 10);
        expect_rsp(0, 20'd55, 1'b0);
        bus.req = 4'b0001;
        run_until_rsp(40);
        ex = sb.pop_front();
        n_cmp++;
        if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
            n_err++;
            $display("[TB] FAIL single_rsp: ack=%b rsp=%b data=%0d err=%b, required ack=%b rsp=%b data=%0d err=%b",
                     ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
        end
        n_cmp++;
        if (ack_n != 1 || start_cyc != ack_cyc) begin
            n_err++;
            $display("[TB] FAIL single_ack_latency: ack after %0d cycles start_cyc=%0d ack_cyc=%0d, required 1 cycle with start together",
                     ack_n, start_cyc, ack_cyc);
        end
        n_cmp++;
        if (rsp_cyc - done_cyc != 1) begin
            n_err++;
            $display("[TB] FAIL single_rsp_latency: rsp %0d cycles after done, required 1", rsp_cyc - done_cyc);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        set_idx(2, 31);
        expect_rsp(2, 20'hFFFFF, 1'b1);
        bus.req = 4'b0100;
        run_until_rsp(10);
        ex = sb.pop_front();
        n_cmp++;
        if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
            n_err++;
            $display("[TB] FAIL ovf_rsp: ack=%b rsp=%b data=%h err=%b, required ack=%b rsp=%b data=%h err=%b",
                     ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
        end
        n_cmp++;
        if (ack_n != 1 || ack_cyc != rsp_cyc) begin
            n_err++;
            $display("[TB] FAIL ovf_timing: ack after %0d cycles ack_cyc=%0d rsp_cyc=%0d, required 1 cycle and same cycle",
                     ack_n, ack_cyc, rsp_cyc);
        end
        n_cmp++;
        if (start_cyc != -1) begin
            n_err++;
            $display("[TB] FAIL ovf_no_start: fib_start seen at cycle %0d, required never", start_cyc);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        core_hang = 1'b1;
        set_idx(3, 12);
        expect_rsp(3, 20'd0, 1'b1);
        bus.req = 4'b1000;
        run_until_rsp(100);
        ex = sb.pop_front();
        n_cmp++;
        if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
            n_err++;
            $display("[TB] FAIL timeout_rsp: ack=%b rsp=%b data=%0d err=%b, required ack=%b rsp=%b data=%0d err=%b",
                     ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
        end
        n_cmp++;
        if (start_cyc < 0 || rsp_cyc - start_cyc != 64) begin
            n_err++;
            $display("[TB] FAIL timeout_latency: rsp %0d cycles after start (start_cyc=%0d), required 64",
                     rsp_cyc - start_cyc, start_cyc);
        end
        core_hang = 1'b0;
    endtask

    task automatic test_core_busy();
        @(negedge clk);
        core_force_busy = 1'b1;
        set_idx(1, 6);
        expect_rsp(1, 20'd8, 1'b0);
        bus.req = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.req_ack, busy} !== '0) begin
                n_err++;
                $display("[TB] FAIL busy_hold%0d: ack=%b busy=%b, required ack=0000 busy=0", n, bus.req_ack, busy);
            end
        end
        core_force_busy = 1'b0;
        run_until_rsp(40);
        n_cmp++;
        if (ack_n != 1) begin
            n_err++;
            $display("[TB] FAIL busy_release_ack: ack after %0d cycles, required 1", ack_n);
        end
        ex = sb.pop_front();
        n_cmp++;
        if ({ack_vec, rsp_vec, rsp_d, rsp_e} !== {ex.vec, ex.vec, ex.data, ex.err}) begin
            n_err++;
            $display("[TB] FAIL busy_rsp: ack=%b rsp=%b data=%0d err=%b, required ack=%b rsp=%b data=%0d err=%b",
                     ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
        end
    endtask

    task automatic test_spurious_done();
        @(negedge clk);
        spur_done = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            spur_done = 1'b0;
            n_cmp++;
            if ({bus.rsp_valid, busy} !== '0) begin
                n_err++;
                $display("[TB] FAIL spurious_done%0d: rsp=%b busy=%b, required rsp=0000 busy=0", n, bus.rsp_valid, busy);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ack_seen;
        int seen;
        @(negedge clk);
        set_idx(0, 15);
        bus.req = 4'b0001;
        ack_seen = 0;
        for (int n = 0; n < 10 && !ack_seen; n++) begin
            @(negedge clk);
            if (bus.req_ack[0]) begin
                ack_seen = 1;
                bus.req  = '0;
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ack_seen || busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rw_in_wait: ack_seen=%0d busy=%b, required ack_seen=1 busy=1", ack_seen, busy);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i} !== '0) begin
            n_err++;
            $display("[TB] FAIL rw_reset_outputs: ack=%b vld=%b data=%h err=%b busy=%b start=%b i=%0d, required all 0",
                     bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.rsp_err, busy, fib_start, fib_i);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("[TB] FAIL rw_no_rsp: %0d responses after reset, required 0", seen);
        end
        set_idx(0, 0);
        expect_rsp(0, 20'd0, 1'b0);
        bus.req = 4'b0001;
        run_until_rsp(40);
        ex = sb.pop_front();
        n_cmp++;
        if ({got, ack_vec, rsp_vec, rsp_d, rsp_e} !== {1'b1, ex.vec, ex.vec, ex.data, ex.err}) begin
            n_err++;
            $display("[TB] FAIL rw_idx0: got=%0d ack=%b rsp=%b data=%0d err=%b, required got=1 ack=%b rsp=%b data=%0d err=%b",
                     got, ack_vec, rsp_vec, rsp_d, rsp_e, ex.vec, ex.vec, ex.data, ex.err);
        end
    endtask

    task automatic test_rsp_count();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (n_rsp_seen != n_pushed || sb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL rsp_count: %0d responses seen, %0d left queued, required %0d seen and 0 queued",
                     n_rsp_seen, sb.size(), n_pushed);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_overflow();
        test_timeout();
        test_core_busy();
        test_spurious_done();
        test_reset_in_wait();
        test_rsp_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
